// File: rtl/replay_fifo_pkg.sv
// -----------------------------------------------------------------------------
// replay_fifo_pkg
// Shared helper for the replay FIFO slice. It holds only the pointer-width
// function, so the interface and the top level derive PW the same way.
// -----------------------------------------------------------------------------
package replay_fifo_pkg;

  // Pointer width: index bits plus one wrap bit, so full and empty can be
  // told apart when the indices coincide.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/replay_fifo_if.sv
// -----------------------------------------------------------------------------
// replay_fifo_if
// Bundles the producer/consumer handshake of the replay FIFO.
//   master : enqueue, din, dequeue, commit, rewind driven; status observed
//   slave  : the FIFO side; consumes requests, drives dout/dout_valid,
//            full, empty, count (unread) and held (dequeued, uncommitted)
// -----------------------------------------------------------------------------
interface replay_fifo_if #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 256
);
  import replay_fifo_pkg::*;

  localparam int PW = ptr_width(DEPTH);

  logic              enqueue;
  logic [DATA_W-1:0] din;
  logic              dequeue;
  logic              commit;
  logic              rewind;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [PW-1:0]     count;
  logic [PW-1:0]     held;

  modport master (
    output enqueue, din, dequeue, commit, rewind,
    input  dout, dout_valid, full, empty, count, held
  );

  modport slave (
    input  enqueue, din, dequeue, commit, rewind,
    output dout, dout_valid, full, empty, count, held
  );

endinterface

// File: rtl/replay_fifo_mem.sv
// -----------------------------------------------------------------------------
// replay_fifo_mem
// DEPTH x DATA_W storage with one synchronous write port and one synchronous
// (registered) read port. Nothing here is reset; the read register simply
// holds its last value when rd_en is low.
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request
//   rd_data          : registered read data, valid the cycle after rd_en
// -----------------------------------------------------------------------------
module replay_fifo_mem #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/replay_fifo.sv
// -----------------------------------------------------------------------------
// replay_fifo
// FIFO with a commit/rewind replay window. Dequeued entries stay in storage
// until committed; a rewind moves the read pointer back to the commit pointer
// so the uncommitted entries are replayed in their original order.
//   clk, rst : clock and synchronous active-high reset
//   bus      : replay_fifo_if slave port
//              enqueue/din      write request (dropped when full)
//              dequeue          read request (ignored when empty or rewinding)
//              commit           release everything dequeued before this cycle
//              rewind           replay held entries (commit wins if both)
//              dout/dout_valid  registered read data and 1-cycle valid pulse
//              full/empty       flags from the registered pointers
//              count/held       unread entries / dequeued-uncommitted entries
// -----------------------------------------------------------------------------
module replay_fifo
  import replay_fifo_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst,
  replay_fifo_if.slave  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     cm_ptr;
  logic              full_w;
  logic              empty_w;
  logic              enq_ok;
  logic              deq_ok;
  logic              rewind_ok;
  logic              vld_p1;
  logic              live_p1;
  logic [DATA_W-1:0] rd_data_p1;

  // Occupancy counts held entries too: space is only reclaimed on commit.
  assign full_w    = ((wr_ptr - cm_ptr) == PW'(DEPTH));
  assign empty_w   = (rd_ptr == wr_ptr);
  assign enq_ok    = bus.enqueue && !full_w && !rst;
  assign deq_ok    = bus.dequeue && !empty_w && !bus.rewind && !rst;
  assign rewind_ok = bus.rewind && !bus.commit;

  replay_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq_ok),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.din),
    .rd_en   (deq_ok),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data_p1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cm_ptr  <= '0;
      vld_p1  <= 1'b0;
      live_p1 <= 1'b0;
    end else begin
      if (enq_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // Commit captures rd before this cycle's dequeue, so an entry read in
      // the same cycle stays held.
      if (bus.commit) begin
        cm_ptr <= rd_ptr;
      end
      if (rewind_ok) begin
        rd_ptr <= cm_ptr;
      end else if (deq_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      vld_p1 <= deq_ok;
      if (deq_ok) begin
        live_p1 <= 1'b1;
      end
    end
  end

  // ---- stage p1: registered read outputs ----
  // The storage read register has no reset; live_p1 forces dout to zero
  // until the first dequeue after reset.
  assign bus.dout       = live_p1 ? rd_data_p1 : '0;
  assign bus.dout_valid = vld_p1;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.count      = wr_ptr - rd_ptr;
  assign bus.held       = rd_ptr - cm_ptr;

endmodule

// File: tb/tb_replay_fifo.sv
module tb_replay_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  replay_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  replay_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  // Scoreboard of expected dout values, and an unbounded reference history
  // addressed by absolute (never-wrapping) pointers.
  logic [DW-1:0] sb[$];
  logic [DW-1:0] hist[$];
  int            mwr, mrd, mcm;
  logic [DW-1:0] mdout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [DW-1:0] d,
                      input logic dq, input logic c, input logic rw);
    bit            full_m, empty_m, deq_ok, exp_vld;
    int            old_rd, old_cm;
    logic [DW-1:0] got;
    rst         = r;
    bus.enqueue = e;
    bus.din     = d;
    bus.dequeue = dq;
    bus.commit  = c;
    bus.rewind  = rw;
    exp_vld     = 1'b0;
    if (r) begin
      mwr = 0; mrd = 0; mcm = 0;
      hist.delete();
      sb.delete();
      mdout = '0;
    end else begin
      full_m  = ((mwr - mcm) == DP);
      empty_m = (mrd == mwr);
      deq_ok  = dq && !empty_m && !rw;
      exp_vld = deq_ok;
      old_rd  = mrd;
      old_cm  = mcm;
      if (deq_ok) begin
        sb.push_back(hist[old_rd]);
        mdout = hist[old_rd];
      end
      if (e && !full_m) begin
        hist.push_back(d);
        mwr++;
      end
      if (c) mcm = old_rd;
      if (rw && !c) mrd = old_cm;
      else if (deq_ok) mrd = old_rd + 1;
    end
    @(posedge clk);
    #1;
    chk("dout_valid", {31'd0, bus.dout_valid}, {31'd0, exp_vld});
    if (bus.dout_valid === 1'b1) begin
      ntests++;
      assert (sb.size() != 0) else begin
        nfail++;
        $error("FAIL sb_underflow: observed unexpected dout %0h expected no output", bus.dout);
      end
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("dout", {24'd0, bus.dout}, {24'd0, got});
      end
    end else begin
      chk("dout_hold", {24'd0, bus.dout}, {24'd0, mdout});
    end
    chk("full",  {31'd0, bus.full},  {31'd0, 1'b1 & ((mwr - mcm) == DP)});
    chk("empty", {31'd0, bus.empty}, {31'd0, 1'b1 & (mrd == mwr)});
    chk("count", {29'd0, bus.count}, 32'(mwr - mrd));
    chk("held",  {29'd0, bus.held},  32'(mrd - mcm));
  endtask

  task automatic enq(input logic [DW-1:0] v); step(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0); endtask
  task automatic deq();                       step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic cmt();                       step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0); endtask
  task automatic rwd();                       step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    rst = 1'b1;
    bus.enqueue = 1'b0; bus.din = '0; bus.dequeue = 1'b0;
    bus.commit = 1'b0; bus.rewind = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Basic order: 3, 1, 2
    enq(8'd3); enq(8'd1); enq(8'd2);
    deq(); deq(); deq();

    // Replay, commit, then a rewind with nothing held
    rwd();
    deq(); deq(); deq();
    cmt();
    rwd();
    deq();

    // Full handling with held entries
    enq(8'hA0); enq(8'hA1); enq(8'hA2); enq(8'hA3);
    enq(8'h55);
    deq(); deq();
    cmt();
    enq(8'hA4); enq(8'hA5);
    deq();
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);   // enqueue while full + commit
    deq(); deq(); deq(); deq();
    cmt();

    // Wrap-around rounds, then a held region covering every index
    for (int i = 0; i < 10; i++) begin
      enq(8'h10 + 8'(i));
      deq();
      cmt();
    end
    enq(8'hC0); enq(8'hC1); enq(8'hC2); enq(8'hC3);
    deq(); deq(); deq(); deq();
    rwd();
    deq(); deq(); deq(); deq();
    cmt();

    // Dequeue + rewind together
    enq(8'hB0); enq(8'hB1);
    deq();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    // Commit + rewind together
    deq();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    // Enqueue + dequeue at count = 1
    step(1'b0, 1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
    deq(); deq();
    cmt();

    // Reset mid-burst with held = 2, count = 2
    enq(8'hE0); enq(8'hE1); enq(8'hE2); enq(8'hE3);
    deq(); deq();
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    enq(8'hF0);
    deq();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
